modulo_envase_multilinhas: RTL and testbench
============================================

# modulo_envase_multilinhas

Parametrised multi-lane filling and sealing controller for the bottling line. It runs LANES independent fill/seal state machines. All lanes share one cork reservoir with round-robin cork arbitration, manual load and automatic refill. It also keeps a dozen/batch tally of accepted bottles. It replaces the single-lane controller and feeds the existing display codifiers and 7-segment multiplexing unchanged.

## Interface
- LANES, 2, number of filling lanes (1..8)
- CORK_W, 7, cork reservoir width in bits
- CORK_MAX, 99, reservoir capacity; also the largest accepted stored value
- CORK_MIN, 5, auto-refill threshold (refill when reservoir <= CORK_MIN)
- REFILL, 20, corks added per auto-refill
- CORK_INIT, 0, reservoir value at reset
- DOZ_MAX, 10, dozen count at which the batch wraps
- clk  in  1  system clock (divided clock domain)
- Nclr  in  1  asynchronous active-low reset
- start_stop  in  1  level enable for all lanes
- pg  in  LANES  bottle-in-position sensor per lane
- ch  in  LANES  bottle-full sensor per lane
- cq  in  LANES  bottle-accepted (quality) sensor per lane
- op_load  in  1  one-cycle manual cork load strobe
- load_val  in  CORK_W  corks to add on op_load
- auto_en  in  1  enable automatic refill
- clr_count  in  1  synchronous clear of dozen/unit counters
- m  out  LANES  conveyor motor per lane
- ev  out  LANES  fill valve per lane
- ve  out  LANES  sealing pulse per lane (one cycle per cork)
- al  out  1  alarm: reservoir empty
- load_rej  out  1  one-cycle pulse: manual load rejected
- rolhas  out  CORK_W  current reservoir count
- unidades  out  4  bottles within current dozen (0..11)
- duzias  out  4  completed dozens (0..DOZ_MAX-1)
- lote  out  1  one-cycle pulse on batch wrap

## Operation
- Each lane has a 2-bit FSM: PARADO(0), ESTEIRA(1), ENCHENDO(2), VEDANDO(3).
- PARADO -> ESTEIRA when start_stop=1. ESTEIRA (m=1) -> ENCHENDO when pg. ENCHENDO (ev=1) -> VEDANDO when ch. VEDANDO holds with all outputs low and requests a cork. When the lane is granted, ve=1 for that cycle and the lane moves to ESTEIRA.
- start_stop=0 forces every lane to PARADO on the next edge, dropping any pending request.
- m, ev and ve are Moore outputs; ve is gated by grant.
- Arbiter: at most one grant per cycle, and only when rolhas>0. Grants rotate round-robin, starting after the last granted lane; after reset lane 0 has priority.
- Reservoir next value = rolhas − grant + add.
  - If op_load=1, add = load_val. When the result would exceed CORK_MAX, the load is dropped entirely (add=0) and load_rej pulses.
  - Otherwise, if auto_en=1 and rolhas<=CORK_MIN, add = REFILL, applied only when the result stays <= CORK_MAX.
  - Manual load takes priority over auto-refill in the same cycle.
  - All arithmetic uses CORK_W+1 bits, so it never wraps.
- al = (rolhas==0), combinational from the register.
- Count event = |(ve & cq).
  - unidades increments on each count event; 11 -> 0 with a carry into duzias.
  - duzias at DOZ_MAX-1 plus a carry goes to 0 and pulses lote.
  - clr_count and a rising edge of start_stop both zero unidades and duzias; clear wins over a same-cycle count.

## Timing
- Reset values: all lanes PARADO; m, ev, ve = 0; rolhas = CORK_INIT; al = (CORK_INIT==0); unidades = duzias = 0; lote = load_rej = 0; arbiter pointer at lane 0.
- Sensor to state change takes one clock. The output follows the state register, so sensor-to-output latency is one cycle.
- Reaching VEDANDO produces the earliest ve on the next cycle, provided rolhas>0 and no other lane holds priority.
- rolhas, al, unidades and duzias update on the edge after the grant or load cycle.
- An empty reservoir stalls lanes in VEDANDO with no ve. When the reservoir becomes nonzero, grants resume the next cycle.
- Reset asserted mid-operation clears everything asynchronously. Deassertion is synchronised by the existing reset conditioning upstream.

## Test plan
- Single lane, CORK_INIT=30, start_stop=1, pulse pg, then ch → m, ev and ve each appear one cycle after their trigger; rolhas goes 30→29; lane returns to ESTEIRA.
- Both lanes in VEDANDO the same cycle, rolhas=10 → lane 0 ve first, lane 1 ve next cycle; rolhas 10→9→8; the next contention grants lane 0 again only after lane 1 has been served.
- rolhas=6, auto_en=1, one seal → rolhas 5; next edge rolhas 25. With rolhas=90 and op_load with load_val=15 → load_rej pulse, rolhas stays 90.
- rolhas=0, lane in VEDANDO → al=1, no ve. op_load with load_val=3 → rolhas=3 next edge, al=0, ve the following cycle.
- 120 seals with cq=1 → unidades wraps every 12; duzias reaches 9, then wraps to 0 with a single lote pulse at the 120th bottle.
- Nclr pulsed low while lanes are in ENCHENDO/VEDANDO → all outputs take their reset values immediately; rolhas = CORK_INIT.

Source files
------------

// File: rtl/modulo_envase_multilinhas_if.sv
// Bundle of the bottling-line controller's sensor, command and display signals.
// Master drives start_stop, pg/ch/cq, op_load/load_val, auto_en and clr_count.
// Slave drives m/ev/ve, al, load_rej, rolhas, unidades, duzias and lote.
interface modulo_envase_multilinhas_if #(
  parameter int LANES  = 2,
  parameter int CORK_W = 7
);
  logic              start_stop;
  logic [LANES-1:0]  pg;
  logic [LANES-1:0]  ch;
  logic [LANES-1:0]  cq;
  logic              op_load;
  logic [CORK_W-1:0] load_val;
  logic              auto_en;
  logic              clr_count;

  logic [LANES-1:0]  m;
  logic [LANES-1:0]  ev;
  logic [LANES-1:0]  ve;
  logic              al;
  logic              load_rej;
  logic [CORK_W-1:0] rolhas;
  logic [3:0]        unidades;
  logic [3:0]        duzias;
  logic              lote;

  modport master (
    output start_stop, pg, ch, cq, op_load, load_val, auto_en, clr_count,
    input  m, ev, ve, al, load_rej, rolhas, unidades, duzias, lote
  );

  modport slave (
    input  start_stop, pg, ch, cq, op_load, load_val, auto_en, clr_count,
    output m, ev, ve, al, load_rej, rolhas, unidades, duzias, lote
  );
endinterface

// File: rtl/modulo_envase_multilinhas.sv
// Multi-lane fill/seal controller: LANES lane FSMs sharing one cork reservoir
// (round-robin cork grant, manual load, auto-refill) plus a dozen/batch tally.
// Latency: sensor -> state/output one clock; ve is combinational from state and grant.
// Backpressure: an empty reservoir stalls lanes in VEDANDO until corks arrive.
// Ports: clk, Nclr (async active-low), bus (slave side of modulo_envase_multilinhas_if).
module modulo_envase_multilinhas #(
  parameter int LANES     = 2,
  parameter int CORK_W    = 7,
  parameter int CORK_MAX  = 99,
  parameter int CORK_MIN  = 5,
  parameter int REFILL    = 20,
  parameter int CORK_INIT = 0,
  parameter int DOZ_MAX   = 10
) (
  input logic                        clk,
  input logic                        Nclr,
  modulo_envase_multilinhas_if.slave bus
);
  localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CORK_W:0] MAX_E    = (CORK_W+1)'(CORK_MAX);
  localparam logic [CORK_W:0] MIN_E    = (CORK_W+1)'(CORK_MIN);
  localparam logic [CORK_W:0] REFILL_E = (CORK_W+1)'(REFILL);
  localparam logic [3:0]      DOZ_LAST = 4'(DOZ_MAX - 1);

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    ESTEIRA  = 2'd1,
    ENCHENDO = 2'd2,
    VEDANDO  = 2'd3
  } lane_state_t;

  lane_state_t       state_q [LANES];
  lane_state_t       state_d [LANES];
  logic [LANES-1:0]  m_w, ev_w;
  logic [LANES-1:0]  req, gnt;
  logic              gnt_any;
  logic [PW-1:0]     prio_q, prio_d, idx;
  logic [CORK_W-1:0] rolhas_q, rolhas_d;
  logic [CORK_W:0]   base, sum_load, sum_fill;
  logic              load_rej_q, load_rej_d;
  logic [3:0]        unid_q, unid_d, duz_q, duz_d;
  logic              lote_q, lote_d;
  logic              ss_q;
  logic              cnt_ev, clear;

  // Round-robin arbiter: search starts at prio_q; the pointer moves just past
  // the winner. A lane only requests while start_stop is high, so a stop drops
  // its request in the same cycle and no cork is consumed.
  always_comb begin
    req     = '0;
    gnt     = '0;
    gnt_any = 1'b0;
    prio_d  = prio_q;
    idx     = '0;
    for (int i = 0; i < LANES; i++) begin
      req[i] = bus.start_stop && (state_q[i] == VEDANDO);
    end
    if (rolhas_q != '0) begin
      for (int i = 0; i < LANES; i++) begin
        idx = PW'((int'(prio_q) + i) % LANES);
        if (!gnt_any && req[idx]) begin
          gnt[idx] = 1'b1;
          gnt_any  = 1'b1;
          prio_d   = PW'((int'(idx) + 1) % LANES);
        end
      end
    end
  end

  // Lane next-state and Moore outputs
  always_comb begin
    m_w  = '0;
    ev_w = '0;
    for (int i = 0; i < LANES; i++) begin
      state_d[i] = state_q[i];
      m_w[i]     = (state_q[i] == ESTEIRA);
      ev_w[i]    = (state_q[i] == ENCHENDO);
      if (!bus.start_stop) begin
        state_d[i] = PARADO;
      end else begin
        case (state_q[i])
          PARADO:   state_d[i] = ESTEIRA;
          ESTEIRA:  if (bus.pg[i]) state_d[i] = ENCHENDO;
          ENCHENDO: if (bus.ch[i]) state_d[i] = VEDANDO;
          VEDANDO:  if (gnt[i])    state_d[i] = ESTEIRA;
          default:  state_d[i] = PARADO;
        endcase
      end
    end
  end

  // Reservoir: one extra bit of headroom so sums never wrap. base cannot
  // underflow because a grant requires rolhas_q > 0.
  always_comb begin
    base       = {1'b0, rolhas_q} - {{CORK_W{1'b0}}, gnt_any};
    sum_load   = base + {1'b0, bus.load_val};
    sum_fill   = base + REFILL_E;
    rolhas_d   = base[CORK_W-1:0];
    load_rej_d = 1'b0;
    if (bus.op_load) begin
      if (sum_load > MAX_E) begin
        load_rej_d = 1'b1;
      end else begin
        rolhas_d = sum_load[CORK_W-1:0];
      end
    end else if (bus.auto_en && ({1'b0, rolhas_q} <= MIN_E) && (sum_fill <= MAX_E)) begin
      rolhas_d = sum_fill[CORK_W-1:0];
    end
  end

  // Dozen/batch tally; a clear (explicit or start_stop rising) beats a count.
  always_comb begin
    cnt_ev = |(gnt & bus.cq);
    clear  = bus.clr_count | (bus.start_stop & ~ss_q);
    unid_d = unid_q;
    duz_d  = duz_q;
    lote_d = 1'b0;
    if (clear) begin
      unid_d = '0;
      duz_d  = '0;
    end else if (cnt_ev) begin
      if (unid_q == 4'd11) begin
        unid_d = '0;
        if (duz_q == DOZ_LAST) begin
          duz_d  = '0;
          lote_d = 1'b1;
        end else begin
          duz_d = duz_q + 4'd1;
        end
      end else begin
        unid_d = unid_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge Nclr) begin
    if (!Nclr) begin
      for (int i = 0; i < LANES; i++) state_q[i] <= PARADO;
      prio_q     <= '0;
      rolhas_q   <= CORK_W'(CORK_INIT);
      load_rej_q <= 1'b0;
      unid_q     <= '0;
      duz_q      <= '0;
      lote_q     <= 1'b0;
      ss_q       <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) state_q[i] <= state_d[i];
      prio_q     <= prio_d;
      rolhas_q   <= rolhas_d;
      load_rej_q <= load_rej_d;
      unid_q     <= unid_d;
      duz_q      <= duz_d;
      lote_q     <= lote_d;
      ss_q       <= bus.start_stop;
    end
  end

  assign bus.m        = m_w;
  assign bus.ev       = ev_w;
  assign bus.ve       = gnt;
  assign bus.al       = (rolhas_q == '0);
  assign bus.load_rej = load_rej_q;
  assign bus.rolhas   = rolhas_q;
  assign bus.unidades = unid_q;
  assign bus.duzias   = duz_q;
  assign bus.lote     = lote_q;
endmodule

// File: tb/tb_modulo_envase_multilinhas.sv
`timescale 1ns/1ps
module tb_modulo_envase_multilinhas;
  localparam int LANES  = 2;
  localparam int CORK_W = 7;

  logic clk  = 1'b0;
  logic Nclr = 1'b0;
  always #5 clk = ~clk;

  modulo_envase_multilinhas_if #(.LANES(LANES), .CORK_W(CORK_W)) bus();

  modulo_envase_multilinhas #(
    .LANES(LANES), .CORK_W(CORK_W), .CORK_MAX(99), .CORK_MIN(5),
    .REFILL(20), .CORK_INIT(0), .DOZ_MAX(10)
  ) dut (
    .clk (clk),
    .Nclr(Nclr),
    .bus (bus)
  );

  int n_chk    = 0;
  int n_fail   = 0;
  int lote_cnt = 0;
  int timeouts = 0;

  always @(negedge clk) if (bus.lote) lote_cnt++;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.start_stop = 1'b0; bus.pg = '0; bus.ch = '0; bus.cq = '0;
    bus.op_load = 1'b0; bus.load_val = '0; bus.auto_en = 1'b0; bus.clr_count = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    Nclr = 1'b0;
    tick();
    Nclr = 1'b1;
  endtask

  task automatic load(input int v);
    bus.op_load  = 1'b1;
    bus.load_val = CORK_W'(v);
    tick();
    bus.op_load  = 1'b0;
  endtask

  // Waits (bounded) for lane 0's seal pulse, then crosses the grant edge.
  task automatic seal_one;
    int k = 0;
    while (!bus.ve[0] && k < 10) begin
      tick();
      k++;
    end
    if (!bus.ve[0]) timeouts++;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    #2;
    // Reset state
    chk("rst_m", int'(bus.m), 0);
    chk("rst_ev", int'(bus.ev), 0);
    chk("rst_ve", int'(bus.ve), 0);
    chk("rst_rolhas", int'(bus.rolhas), 0);
    chk("rst_al", int'(bus.al), 1);
    chk("rst_unid", int'(bus.unidades), 0);
    chk("rst_duz", int'(bus.duzias), 0);
    chk("rst_lote", int'(bus.lote), 0);
    chk("rst_rej", int'(bus.load_rej), 0);
    tick();
    Nclr = 1'b1;

    // Single lane pass with 30 corks
    load(30);
    chk("t1_rolhas", int'(bus.rolhas), 30);
    chk("t1_al", int'(bus.al), 0);
    bus.start_stop = 1'b1;
    tick();
    chk("t1_m_start", int'(bus.m), 3);
    bus.pg = 2'b01;
    tick();
    bus.pg = 2'b00;
    chk("t1_ev", int'(bus.ev), 1);
    chk("t1_m_fill", int'(bus.m), 2);
    bus.ch = 2'b01;
    tick();
    bus.ch = 2'b00;
    chk("t1_ve", int'(bus.ve), 1);
    chk("t1_ev_off", int'(bus.ev), 0);
    tick();
    chk("t1_ve_off", int'(bus.ve), 0);
    chk("t1_rolhas29", int'(bus.rolhas), 29);
    chk("t1_m_back", int'(bus.m), 3);

    // Two lanes contend, 10 corks
    do_reset();
    load(10);
    bus.start_stop = 1'b1;
    tick();
    bus.pg = 2'b11;
    tick();
    bus.pg = 2'b00;
    bus.ch = 2'b11;
    tick();
    bus.ch = 2'b00;
    chk("t2_ve_l0", int'(bus.ve), 1);
    chk("t2_rolhas10", int'(bus.rolhas), 10);
    tick();
    chk("t2_ve_l1", int'(bus.ve), 2);
    chk("t2_rolhas9", int'(bus.rolhas), 9);
    tick();
    chk("t2_ve_none", int'(bus.ve), 0);
    chk("t2_rolhas8", int'(bus.rolhas), 8);
    bus.pg = 2'b11;
    tick();
    bus.pg = 2'b00;
    bus.ch = 2'b11;
    tick();
    bus.ch = 2'b00;
    chk("t2_ve_l0_again", int'(bus.ve), 1);
    tick();
    chk("t2_ve_l1_again", int'(bus.ve), 2);
    tick();
    chk("t2_rolhas6", int'(bus.rolhas), 6);

    // Auto refill at the threshold, then rejected manual load
    bus.auto_en = 1'b1;
    bus.pg = 2'b01;
    tick();
    bus.pg = 2'b00;
    bus.ch = 2'b01;
    tick();
    bus.ch = 2'b00;
    chk("t3_ve", int'(bus.ve), 1);
    tick();
    chk("t3_rolhas5", int'(bus.rolhas), 5);
    tick();
    chk("t3_refill25", int'(bus.rolhas), 25);
    load(65);
    chk("t3_rolhas90", int'(bus.rolhas), 90);
    chk("t3_rej_none", int'(bus.load_rej), 0);
    load(15);
    chk("t3_rej_pulse", int'(bus.load_rej), 1);
    chk("t3_rolhas_kept", int'(bus.rolhas), 90);
    tick();
    chk("t3_rej_end", int'(bus.load_rej), 0);
    chk("t3_rolhas_still", int'(bus.rolhas), 90);

    // Empty reservoir stalls sealing until a manual load
    do_reset();
    bus.start_stop = 1'b1;
    tick();
    bus.pg = 2'b01;
    tick();
    bus.pg = 2'b00;
    bus.ch = 2'b01;
    tick();
    bus.ch = 2'b00;
    chk("t4_al", int'(bus.al), 1);
    chk("t4_ve_stall", int'(bus.ve), 0);
    tick();
    chk("t4_ve_stall2", int'(bus.ve), 0);
    chk("t4_m_stall", int'(bus.m), 2);
    load(3);
    chk("t4_rolhas3", int'(bus.rolhas), 3);
    chk("t4_al_off", int'(bus.al), 0);
    chk("t4_ve_resume", int'(bus.ve), 1);
    tick();
    chk("t4_rolhas2", int'(bus.rolhas), 2);
    chk("t4_ve_done", int'(bus.ve), 0);

    // 120 accepted bottles: dozen and batch wrap
    do_reset();
    load(99);
    bus.auto_en = 1'b1;
    bus.start_stop = 1'b1;
    tick();
    bus.pg = 2'b01;
    bus.ch = 2'b01;
    bus.cq = 2'b01;
    for (int n = 0; n < 12; n++) seal_one();
    chk("t5_unid_12", int'(bus.unidades), 0);
    chk("t5_duz_12", int'(bus.duzias), 1);
    seal_one();
    chk("t5_unid_13", int'(bus.unidades), 1);
    for (int n = 13; n < 119; n++) seal_one();
    chk("t5_unid_119", int'(bus.unidades), 11);
    chk("t5_duz_119", int'(bus.duzias), 9);
    chk("t5_lotecnt_119", lote_cnt, 0);
    seal_one();
    chk("t5_unid_120", int'(bus.unidades), 0);
    chk("t5_duz_120", int'(bus.duzias), 0);
    chk("t5_lote_120", int'(bus.lote), 1);
    tick();
    chk("t5_lote_off", int'(bus.lote), 0);
    chk("t5_lotecnt", lote_cnt, 1);
    seal_one();
    seal_one();
    chk("t5_unid_2", int'(bus.unidades), 2);
    bus.clr_count = 1'b1;
    tick();
    bus.clr_count = 1'b0;
    chk("t5_clr", int'(bus.unidades), 0);
    chk("t5_timeouts", timeouts, 0);

    // Asynchronous reset mid-operation
    bus.pg = 2'b11;
    bus.ch = 2'b01;
    tick();
    chk("t6_pre_ev", int'(bus.ev), 2);
    chk("t6_pre_ve", int'(bus.ve), 1);
    #2;
    Nclr = 1'b0;
    #1;
    chk("t6_m", int'(bus.m), 0);
    chk("t6_ev", int'(bus.ev), 0);
    chk("t6_ve", int'(bus.ve), 0);
    chk("t6_rolhas", int'(bus.rolhas), 0);
    chk("t6_al", int'(bus.al), 1);
    idle_inputs();
    tick();
    Nclr = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
